// File: rtl/egg_hatch_scheduler_if.sv
// Bundles the slot-side request/status signals and the generator sample/enable
// lines of the egg-hatch scheduler.
interface egg_hatch_scheduler_if #(
  parameter int NSLOT = 4,
  parameter int TW    = 8
);
  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic             clear;
  logic [NSLOT-1:0] req;
  logic [6:0]       rng_val;
  logic             rng_run;
  logic             busy;
  logic [SW-1:0]    grant_slot;
  logic             load_valid;
  logic [TW-1:0]    load_val;
  logic [NSLOT-1:0] pending;
  logic [NSLOT-1:0] active;
  logic [NSLOT-1:0] hatch;

  modport master (
    output clear, req, rng_val,
    input  rng_run, busy, grant_slot, load_valid, load_val, pending, active, hatch
  );

  modport slave (
    input  clear, req, rng_val,
    output rng_run, busy, grant_slot, load_valid, load_val, pending, active, hatch
  );
endinterface

// File: rtl/egg_hatch_scheduler.sv
// Round-robin grant of the shared RNG to egg slots; each grant settles the RNG,
// samples it, and arms a per-slot hatch countdown of MIN_DELAY + value.
//
// state | meaning
// IDLE  | waiting for a pending slot; picks next one after ptr
// RUN   | rng_run high, settle counter counting down to 0
// LOAD  | rng_run low; rng_val sampled into the granted slot's timer
module egg_hatch_scheduler #(
  parameter int NSLOT     = 4,
  parameter int SETTLE    = 8,
  parameter int MIN_DELAY = 16,
  parameter int TW        = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  egg_hatch_scheduler_if.slave bus
);
  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

  state_t           state;
  logic [7:0]       settle_cnt;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    grant_slot;
  logic             rng_run;
  logic             busy;
  logic             load_valid;
  logic [TW-1:0]    load_val;
  logic [NSLOT-1:0] pending;
  logic [NSLOT-1:0] active;
  logic [NSLOT-1:0] hatch;
  logic [TW-1:0]    timer [NSLOT];

  logic [NSLOT-1:0] grant_mask;
  logic [NSLOT-1:0] accept;
  logic [NSLOT-1:0] clr_mask;
  logic             found;
  logic [SW-1:0]    next_slot;
  logic [TW-1:0]    load_sum;
  logic             do_load;
  int               idx;

  assign load_sum = TW'(MIN_DELAY) + TW'({1'b0, bus.rng_val});
  assign do_load  = (state == LOAD);

  always_comb begin
    grant_mask = '0;
    if (busy) grant_mask[grant_slot] = 1'b1;
    accept = bus.req & ~pending & ~active & ~grant_mask;

    // first pending slot after the last grant, wrapping around
    found     = 1'b0;
    next_slot = ptr;
    idx       = 0;
    for (int k = 1; k <= NSLOT; k++) begin
      idx = (int'(ptr) + k) % NSLOT;
      if (!found && pending[idx]) begin
        found     = 1'b1;
        next_slot = SW'(idx);
      end
    end

    clr_mask = '0;
    if (state == IDLE && found) clr_mask[next_slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      ptr        <= SW'(NSLOT - 1);
      grant_slot <= '0;
      rng_run    <= 1'b0;
      busy       <= 1'b0;
      load_valid <= 1'b0;
      load_val   <= '0;
      pending    <= '0;
    end else if (bus.clear) begin
      state      <= IDLE;
      settle_cnt <= '0;
      rng_run    <= 1'b0;
      busy       <= 1'b0;
      load_valid <= 1'b0;
      pending    <= '0;
    end else begin
      load_valid <= 1'b0;
      pending    <= (pending | accept) & ~clr_mask;
      case (state)
        IDLE: begin
          if (found) begin
            grant_slot <= next_slot;
            ptr        <= next_slot;
            settle_cnt <= 8'(SETTLE - 1);
            rng_run    <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (settle_cnt == 8'd0) begin
            rng_run <= 1'b0;
            state   <= LOAD;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        LOAD: begin
          load_val   <= load_sum;
          load_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // slot timers run independently of the FSM once armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      hatch  <= '0;
      for (int i = 0; i < NSLOT; i++) timer[i] <= '0;
    end else if (bus.clear) begin
      active <= '0;
      hatch  <= '0;
      for (int i = 0; i < NSLOT; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        hatch[i] <= active[i] && (timer[i] == TW'(1));
        if (do_load && grant_slot == SW'(i)) begin
          timer[i]  <= load_sum;
          active[i] <= 1'b1;
        end else if (active[i]) begin
          timer[i] <= timer[i] - TW'(1);
          if (timer[i] == TW'(1)) active[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rng_run    = rng_run;
  assign bus.busy       = busy;
  assign bus.grant_slot = grant_slot;
  assign bus.load_valid = load_valid;
  assign bus.load_val   = load_val;
  assign bus.pending    = pending;
  assign bus.active     = active;
  assign bus.hatch      = hatch;
endmodule
